// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the multi-lane load/store unit: mem_op bit positions,
// lane slice widths, FSM encoding and small op-class helpers.
package mem_lsu_pkg;

    localparam int OP_W           = 8;
    localparam int DATA_W         = 32;
    localparam int REG_W          = 5;
    localparam int ADDR_W_DEFAULT = 32;

    // mem_op is {lb,lbu,lh,lhu,lw,sb,sh,sw}, MSB first
    localparam int OP_LB  = 7;
    localparam int OP_LBU = 6;
    localparam int OP_LH  = 5;
    localparam int OP_LHU = 4;
    localparam int OP_LW  = 3;
    localparam int OP_SB  = 2;
    localparam int OP_SH  = 1;
    localparam int OP_SW  = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } lsu_state_t;

    function automatic logic op_is_store(input logic [OP_W-1:0] op);
        return op[OP_SB] | op[OP_SH] | op[OP_SW];
    endfunction

    function automatic logic op_is_load(input logic [OP_W-1:0] op);
        return op[OP_LB] | op[OP_LBU] | op[OP_LH] | op[OP_LHU] | op[OP_LW];
    endfunction

endpackage

// File: rtl/mem_lsu_fmt.sv
// Combinational formatter for the one access in flight: store strobes/data,
// load extraction/extension, misalignment flag (MEM_LSU_ALIGN_CHECK_EN).
module mem_lsu_fmt
    import mem_lsu_pkg::*;
(
    input  logic [OP_W-1:0]   i_mem_op,
    input  logic [1:0]        i_addr_lo,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [3:0]        o_wstrb,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_load_data,
    output logic              o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_wstrb     = 4'b0000;
        o_wdata     = '0;
        o_load_data = '0;

        if (i_mem_op[OP_LB])  o_load_data = {{24{w_byte[7]}}, w_byte};
        if (i_mem_op[OP_LBU]) o_load_data = {24'd0, w_byte};
        if (i_mem_op[OP_LH])  o_load_data = {{16{w_half[15]}}, w_half};
        if (i_mem_op[OP_LHU]) o_load_data = {16'd0, w_half};
        if (i_mem_op[OP_LW])  o_load_data = i_rdata;

        // Store data is replicated so every byte lane sees it; strobes pick the target
        if (i_mem_op[OP_SB]) begin
            o_wstrb = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
        end
        if (i_mem_op[OP_SH]) begin
            o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata = {2{i_wdata[15:0]}};
        end
        if (i_mem_op[OP_SW]) begin
            o_wstrb = 4'b1111;
            o_wdata = i_wdata;
        end
    end

`ifdef MEM_LSU_ALIGN_CHECK_EN
    assign o_misalign = ((i_mem_op[OP_LH] | i_mem_op[OP_LHU] | i_mem_op[OP_SH]) & i_addr_lo[0])
                      | ((i_mem_op[OP_LW] | i_mem_op[OP_SW]) & (|i_addr_lo));
`else
    assign o_misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_lsu_multi.sv
// Multi-lane MEM stage: serialises each lane's load/store over one valid/ready
// memory port and emits one write-back bundle. Alignment traps via MEM_LSU_ALIGN_CHECK_EN.
module mem_lsu_multi
    import mem_lsu_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_valid,
    input  logic [LANES*OP_W-1:0]   in_mem_op,
    input  logic [LANES*ADDR_W-1:0] in_addr,
    input  logic [LANES*DATA_W-1:0] in_wdata,
    input  logic [LANES*DATA_W-1:0] in_ex_result,
    input  logic [LANES-1:0]        in_rf_we,
    input  logic [LANES*REG_W-1:0]  in_rf_waddr,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic                    req_wr,
    output logic [ADDR_W-1:0]       req_addr,
    output logic [3:0]              req_wstrb,
    output logic [DATA_W-1:0]       req_wdata,
    input  logic                    rsp_valid,
    input  logic [DATA_W-1:0]       rsp_rdata,
    output logic                    out_valid,
    output logic [LANES-1:0]        out_rf_we,
    output logic [LANES*REG_W-1:0]  out_rf_waddr,
    output logic [LANES*DATA_W-1:0] out_rf_wdata,
    output logic [LANES-1:0]        out_exc,
    output logic                    stall_req
);

    localparam int LP_W = (LANES > 1) ? $clog2(LANES) : 1;

    lsu_state_t r_state, w_state_next;
    logic [LP_W-1:0] r_lane_ptr, w_lane_ptr_next;

    logic              r_lane_valid [LANES];
    logic [OP_W-1:0]   r_mem_op     [LANES];
    logic [ADDR_W-1:0] r_addr       [LANES];
    logic [DATA_W-1:0] r_wdata      [LANES];
    logic [DATA_W-1:0] r_result     [LANES];
    logic              r_rf_we      [LANES];
    logic [REG_W-1:0]  r_rf_waddr   [LANES];
    logic              r_exc        [LANES];

    logic [OP_W-1:0]   w_in_op [LANES];
    logic [LANES-1:0]  w_in_mem;
    logic [LANES-1:0]  w_reg_mem;

    logic              w_accept, w_capture, w_fault;
    logic              w_first_found, w_next_found;
    logic [LP_W-1:0]   w_first_idx, w_next_idx;

    logic [OP_W-1:0]   w_cur_op;
    logic [ADDR_W-1:0] w_cur_addr;
    logic [DATA_W-1:0] w_cur_wdata;
    logic [3:0]        w_fmt_wstrb;
    logic [DATA_W-1:0] w_fmt_wdata, w_load_data;
    logic              w_misalign;

    assign w_cur_op    = r_mem_op[r_lane_ptr];
    assign w_cur_addr  = r_addr[r_lane_ptr];
    assign w_cur_wdata = r_wdata[r_lane_ptr];

    mem_lsu_fmt u_fmt (
        .i_mem_op    (w_cur_op),
        .i_addr_lo   (w_cur_addr[1:0]),
        .i_wdata     (w_cur_wdata),
        .i_rdata     (rsp_rdata),
        .o_wstrb     (w_fmt_wstrb),
        .o_wdata     (w_fmt_wdata),
        .o_load_data (w_load_data),
        .o_misalign  (w_misalign)
    );

    assign w_capture = (r_state == WAIT) & rsp_valid & op_is_load(w_cur_op);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_in_op[gi]   = in_mem_op[gi*OP_W +: OP_W];
            assign w_in_mem[gi]  = in_lane_valid[gi] & (|w_in_op[gi]);
            assign w_reg_mem[gi] = r_lane_valid[gi] & (|r_mem_op[gi]);

            // r_result starts as the ALU result and is overwritten only by a load response
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_lane_valid[gi] <= 1'b0;
                    r_mem_op[gi]     <= '0;
                    r_addr[gi]       <= '0;
                    r_wdata[gi]      <= '0;
                    r_result[gi]     <= '0;
                    r_rf_we[gi]      <= 1'b0;
                    r_rf_waddr[gi]   <= '0;
                    r_exc[gi]        <= 1'b0;
                end else if (w_accept) begin
                    r_lane_valid[gi] <= in_lane_valid[gi];
                    r_mem_op[gi]     <= w_in_op[gi];
                    r_addr[gi]       <= in_addr[gi*ADDR_W +: ADDR_W];
                    r_wdata[gi]      <= in_wdata[gi*DATA_W +: DATA_W];
                    r_result[gi]     <= in_ex_result[gi*DATA_W +: DATA_W];
                    r_rf_we[gi]      <= in_rf_we[gi];
                    r_rf_waddr[gi]   <= in_rf_waddr[gi*REG_W +: REG_W];
                    r_exc[gi]        <= 1'b0;
                end else begin
                    if (w_capture && (r_lane_ptr == LP_W'(gi)))
                        r_result[gi] <= w_load_data;
                    if (w_fault && (LP_W'(gi) >= r_lane_ptr)) begin
                        r_rf_we[gi] <= 1'b0;
                        r_exc[gi]   <= (LP_W'(gi) == r_lane_ptr);
                    end
                end
            end

            assign out_rf_we[gi] = out_valid & r_lane_valid[gi] & r_rf_we[gi];
            assign out_exc[gi]   = out_valid & r_exc[gi];
            assign out_rf_waddr[gi*REG_W +: REG_W] =
                (out_valid & r_lane_valid[gi]) ? r_rf_waddr[gi] : '0;
            assign out_rf_wdata[gi*DATA_W +: DATA_W] =
                (out_valid & r_lane_valid[gi]) ? r_result[gi] : '0;
        end
    endgenerate

    // Lowest mem lane of the incoming bundle, and next mem lane above the pointer
    always_comb begin
        w_first_found = 1'b0;
        w_first_idx   = '0;
        w_next_found  = 1'b0;
        w_next_idx    = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (w_in_mem[i]) begin
                w_first_found = 1'b1;
                w_first_idx   = LP_W'(i);
            end
            if (w_reg_mem[i] && (i > int'(r_lane_ptr))) begin
                w_next_found = 1'b1;
                w_next_idx   = LP_W'(i);
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_lane_ptr_next = r_lane_ptr;
        w_accept        = 1'b0;
        w_fault         = 1'b0;
        in_ready        = 1'b0;
        req_valid       = 1'b0;
        out_valid       = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = ~flush;
                if (in_valid && !flush) begin
                    w_accept        = 1'b1;
                    w_lane_ptr_next = w_first_idx;
                    w_state_next    = w_first_found ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (w_misalign) begin
                    w_fault      = ~flush;
                    w_state_next = flush ? IDLE : DONE;
                end else begin
                    req_valid = 1'b1;
                    if (req_ready)
                        w_state_next = flush ? DRAIN : WAIT;
                    else if (flush)
                        w_state_next = IDLE;
                end
            end
            WAIT: begin
                // A response landing with the flush has already been absorbed
                if (rsp_valid) begin
                    if (flush) begin
                        w_state_next = IDLE;
                    end else if (w_next_found) begin
                        w_state_next    = ISSUE;
                        w_lane_ptr_next = w_next_idx;
                    end else begin
                        w_state_next = DONE;
                    end
                end else if (flush) begin
                    w_state_next = DRAIN;
                end
            end
            DONE: begin
                out_valid    = ~flush;
                w_state_next = IDLE;
            end
            DRAIN: begin
                if (rsp_valid)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lane_ptr <= '0;
        end else begin
            r_state    <= w_state_next;
            r_lane_ptr <= w_lane_ptr_next;
        end
    end

    assign req_wr    = req_valid & op_is_store(w_cur_op);
    assign req_addr  = req_valid ? {w_cur_addr[ADDR_W-1:2], 2'b00} : '0;
    assign req_wstrb = req_valid ? w_fmt_wstrb : 4'b0000;
    assign req_wdata = req_valid ? w_fmt_wdata : '0;
    assign stall_req = (r_state != IDLE) | (w_accept & (|w_in_mem));

endmodule

// File: tb/tb_mem_lsu_multi.sv
// Scoreboard bench for mem_lsu_multi: expected requests/bundles are queued at
// drive time and popped when the DUT handshakes a request or pulses out_valid.
module tb_mem_lsu_multi;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [1:0]  in_lane_valid, in_rf_we;
    logic [15:0] in_mem_op;
    logic [63:0] in_addr, in_wdata, in_ex_result;
    logic [9:0]  in_rf_waddr;
    logic        req_valid, req_ready, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        out_valid, stall_req;
    logic [1:0]  out_rf_we, out_exc;
    logic [9:0]  out_rf_waddr;
    logic [63:0] out_rf_wdata;

    always #5 clk = ~clk;

    mem_lsu_multi #(.LANES(2), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_lane_valid(in_lane_valid),
        .in_mem_op(in_mem_op), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_ex_result(in_ex_result), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .out_valid(out_valid), .out_rf_we(out_rf_we), .out_rf_waddr(out_rf_waddr),
        .out_rf_wdata(out_rf_wdata), .out_exc(out_exc), .stall_req(stall_req)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } req_t;
    typedef struct {
        logic [1:0]  we;
        logic [9:0]  waddr;
        logic [63:0] wdata;
        logic [1:0]  exc;
    } out_t;
    typedef struct {
        logic [31:0] rdata;
        int          cnt;
    } pend_t;

    req_t  exp_req[$];
    out_t  exp_out[$];
    pend_t mem_pend[$];
    int    mem_lat = 0;
    int    accept_pend = 0;
    int    n_checks = 0;
    int    n_errors = 0;
    req_t  mon_r;
    out_t  mon_o;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic is_store(input logic [7:0] op);
        return |(op & 8'h07);
    endfunction

    function automatic logic [31:0] ld_model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] b, h;
        b = rd >> (8 * a[1:0]);
        h = rd >> (16 * a[1]);
        case (op)
            8'h80:   return {{24{b[7]}}, b[7:0]};
            8'h40:   return {24'd0, b[7:0]};
            8'h20:   return {{16{h[15]}}, h[15:0]};
            8'h10:   return {16'd0, h[15:0]};
            default: return rd;
        endcase
    endfunction

    task automatic st_model(input logic [7:0] op, input logic [1:0] lo, input logic [31:0] d,
                            output logic [3:0] strb, output logic [31:0] data);
        strb = 4'b0000;
        data = 32'd0;
        case (op)
            8'h04: begin strb = 4'b0001 << lo; data = {d[7:0], d[7:0], d[7:0], d[7:0]}; end
            8'h02: begin strb = lo[1] ? 4'b1100 : 4'b0011; data = {d[15:0], d[15:0]}; end
            8'h01: begin strb = 4'b1111; data = d; end
            default: ;
        endcase
    endtask

`ifdef MEM_LSU_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [7:0] op, input logic [31:0] a);
        if (op == 8'h20 || op == 8'h10 || op == 8'h02) return a[0];
        if (op == 8'h08 || op == 8'h01) return |a[1:0];
        return 1'b0;
    endfunction
`endif

    // Monitor: request handshakes and write-back pulses against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid && req_ready) begin
                check("req_expected", 64'(exp_req.size() > 0), 64'd1);
                if (exp_req.size() > 0) begin
                    mon_r = exp_req.pop_front();
                    check("req_addr", req_addr, mon_r.addr);
                    check("req_wr", req_wr, mon_r.wr);
                    if (mon_r.wr) begin
                        check("req_wstrb", req_wstrb, mon_r.wstrb);
                        check("req_wdata", req_wdata, mon_r.wdata);
                    end
                    $display("req  addr=%08h wr=%0d wstrb=%04b wdata=%08h", req_addr, req_wr, req_wstrb, req_wdata);
                    mem_pend.push_back('{mon_r.rdata, mem_lat});
                end
            end
            if (out_valid) begin
                check("out_expected", 64'(exp_out.size() > 0), 64'd1);
                if (exp_out.size() > 0) begin
                    mon_o = exp_out.pop_front();
                    check("out_rf_we", out_rf_we, mon_o.we);
                    check("out_rf_waddr", out_rf_waddr, mon_o.waddr);
                    check("out_rf_wdata", out_rf_wdata, mon_o.wdata);
                    check("out_exc", out_exc, mon_o.exc);
                    check("out_stall", stall_req, 1);
                    $display("out  we=%02b waddr=%03h wdata=%016h exc=%02b", out_rf_we, out_rf_waddr, out_rf_wdata, out_exc);
                end
            end
        end
    end

    // Memory responder: one response per accepted request after mem_lat idle cycles
    initial begin
        rsp_valid = 1'b0;
        rsp_rdata = 32'hBAD0BAD0;
        forever begin
            @(posedge clk);
            #1;
            rsp_valid = 1'b0;
            rsp_rdata = $urandom;
            if (mem_pend.size() > 0) begin
                if (mem_pend[0].cnt == 0) begin
                    rsp_valid = 1'b1;
                    rsp_rdata = mem_pend[0].rdata;
                    void'(mem_pend.pop_front());
                end else begin
                    mem_pend[0].cnt = mem_pend[0].cnt - 1;
                end
            end
        end
    end

    task automatic send(input logic [1:0] lv, input logic [15:0] op, input logic [63:0] a,
                        input logic [63:0] wd, input logic [63:0] ex, input logic [1:0] we,
                        input logic [9:0] ra, input logic [63:0] rd, input bit expect_out);
        out_t        o;
        req_t        r;
        bit          stop, has_mem, acc;
        logic [7:0]  lop;
        logic [31:0] la, res;
        o.we = '0; o.waddr = '0; o.wdata = '0; o.exc = '0;
        stop = 1'b0; has_mem = 1'b0; acc = 1'b0;
        for (int i = 0; i < 2; i++) begin
            lop = op[8*i +: 8];
            la  = a[32*i +: 32];
            res = ex[32*i +: 32];
            if (lv[i] && lop != 8'h00) has_mem = 1'b1;
            if (lv[i] && !stop) begin
                if (lop != 8'h00) begin
`ifdef MEM_LSU_ALIGN_CHECK_EN
                    if (misaligned(lop, la)) begin
                        o.exc[i] = 1'b1;
                        stop = 1'b1;
                    end
`endif
                    if (!stop) begin
                        r.addr  = {la[31:2], 2'b00};
                        r.wr    = is_store(lop);
                        st_model(lop, la[1:0], wd[32*i +: 32], r.wstrb, r.wdata);
                        r.rdata = rd[32*i +: 32];
                        exp_req.push_back(r);
                        if (!r.wr) res = ld_model(lop, la, r.rdata);
                    end
                end
                o.we[i] = we[i] & ~stop;
                o.waddr[5*i +: 5]  = ra[5*i +: 5];
                o.wdata[32*i +: 32] = res;
            end
        end
        if (expect_out) exp_out.push_back(o);

        in_valid = 1'b1; in_lane_valid = lv; in_mem_op = op; in_addr = a;
        in_wdata = wd; in_ex_result = ex; in_rf_we = we; in_rf_waddr = ra;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                accept_pend = mem_pend.size();
                check("stall_accept", stall_req, has_mem);
                break;
            end
        end
        check("accepted", acc, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mem_op = 16'($urandom);
        in_addr = {$urandom, $urandom};
        in_lane_valid = 2'($urandom);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (exp_out.size() == 0 && exp_req.size() == 0 && mem_pend.size() == 0 && !stall_req) begin
                idle = 1'b1;
                break;
            end
        end
        check("drain_done", idle, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic measure_latency(input string tag, input int exp_cycles);
        int k;
        for (k = 1; k < 50; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check(tag, k, exp_cycles);
    endtask

    logic [7:0]  ops [9];
    logic [7:0]  o0, o1;
    logic [31:0] a0, a1;
    bit          hs;

    function automatic logic [31:0] rand_addr(input logic [7:0] op, input int n);
        logic [31:0] base;
        base = 32'h500 + 32'(16 * n);
        if (op == 8'h80 || op == 8'h40 || op == 8'h04) return base + 32'($urandom_range(0, 3));
        if (op == 8'h20 || op == 8'h10 || op == 8'h02) return base + 32'(2 * $urandom_range(0, 1));
        return base;
    endfunction

    initial begin
        ops = '{8'h00, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; req_ready = 1'b1;
        in_lane_valid = '0; in_mem_op = '0; in_addr = '0; in_wdata = '0;
        in_ex_result = '0; in_rf_we = '0; in_rf_waddr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_req_valid", req_valid, 0);
        check("rst_stall", stall_req, 0);
        check("rst_out_we", out_rf_we, 0);
        check("rst_out_exc", out_exc, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // No mem lanes, lane1 invalid: write-back one cycle after accept
        send(2'b01, 16'h0000, {32'h0, 32'h0}, 64'h0, {32'h99, 32'h11}, 2'b11, {5'd2, 5'd1}, 64'h0, 1);
        measure_latency("lat_nomem", 1);
        wait_idle();

        // add + lw with three-cycle memory; stall held until write-back
        mem_lat = 3;
        send(2'b11, {8'h08, 8'h00}, {32'h100, 32'h0}, 64'h0, {32'h0, 32'h55}, 2'b11,
             {5'd5, 5'd3}, {32'hDEADBEEF, 32'h0}, 1);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid) break;
            check("stall_busy", stall_req, 1);
        end
        wait_idle();

        // lb / lbu, zero-wait memory: write-back 1+2M cycles after accept
        mem_lat = 0;
        send(2'b11, {8'h40, 8'h80}, {32'h102, 32'h103}, 64'h0, {32'h2, 32'h1}, 2'b11,
             {5'd7, 5'd6}, {32'h80FF0000, 32'h80FF0000}, 1);
        measure_latency("lat_two_loads", 5);
        wait_idle();

        // sh / sb stores
        send(2'b11, {8'h04, 8'h02}, {32'h201, 32'h202}, {32'h77, 32'h1234ABCD},
             {32'hB, 32'hA}, 2'b00, {5'd0, 5'd0}, 64'h0, 1);
        wait_idle();

        // Flush while waiting: DRAIN eats the late response, no write-back
        mem_lat = 3;
        send(2'b11, {8'h00, 8'h08}, {32'h0, 32'h400}, 64'h0, {32'h3, 32'h4}, 2'b11,
             {5'd9, 5'd8}, {32'h0, 32'h11112222}, 0);
        hs = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_valid && req_ready) begin hs = 1'b1; break; end
        end
        check("flush_handshake", hs, 1);
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        check("drain_stall", stall_req, 1);
        check("drain_in_ready", in_ready, 0);
        send(2'b01, 16'h0000, 64'h0, 64'h0, {32'h0, 32'h66}, 2'b01, {5'd0, 5'd10}, 64'h0, 1);
        check("drain_before_accept", accept_pend, 0);
        wait_idle();

        // req_ready held low: request fields stable, nothing extra issued
        mem_lat = 1;
        req_ready = 1'b0;
        send(2'b11, {8'h10, 8'h01}, {32'h306, 32'h300}, {32'h0, 32'hCAFEF00D},
             {32'h0, 32'h0}, 2'b10, {5'd12, 5'd11}, {32'h5A5A1234, 32'h0}, 1);
        repeat (5) begin
            @(negedge clk);
            check("hold_req_valid", req_valid, 1);
            check("hold_req_addr", req_addr, 32'h300);
            check("hold_req_wstrb", req_wstrb, 4'b1111);
            check("hold_req_wdata", req_wdata, 32'hCAFEF00D);
        end
        @(posedge clk); #1; req_ready = 1'b1;
        wait_idle();

        // Flush wins over a bundle offered in the same cycle
        in_valid = 1'b1; flush = 1'b1; in_lane_valid = 2'b01; in_mem_op = 16'h0000;
        @(negedge clk);
        check("flush_blocks_ready", in_ready, 0);
        check("flush_no_stall", stall_req, 0);
        @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;

`ifdef MEM_LSU_ALIGN_CHECK_EN
        // Misaligned lw on lane0 traps; lane1 suppressed too
        send(2'b11, {8'h08, 8'h08}, {32'h200, 32'h102}, 64'h0, {32'h2, 32'h1}, 2'b11,
             {5'd14, 5'd13}, {32'h1, 32'h2}, 1);
        wait_idle();
`endif

        // Mixed random bundles
        for (int n = 0; n < 8; n++) begin
            mem_lat = $urandom_range(0, 2);
            o0 = ops[$urandom_range(0, 8)];
            o1 = ops[$urandom_range(0, 8)];
            a0 = rand_addr(o0, 2 * n);
            a1 = rand_addr(o1, 2 * n + 1);
            send(2'($urandom_range(1, 3)), {o1, o0}, {a1, a0}, {$urandom, $urandom},
                 {$urandom, $urandom}, 2'($urandom), 10'($urandom), {$urandom, $urandom}, 1);
            wait_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
